// File: rtl/exp_taylor_datapath.sv
// exp_taylor_datapath: truncated Taylor-series e^x datapath (term recursion, sum, term counter)
// driven by the exponential control unit through ldX/ldTmp/selTmp, returning done.
module exp_taylor_datapath #(
  parameter int TERMS = 8,
  parameter int FRAC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x_in,
  input  logic        ldX,
  input  logic        ldTmp,
  input  logic        selTmp,
  output logic        done,
  output logic [17:0] result,
  output logic [16:0] term
);
  localparam logic [3:0] TERMS_C = 4'(TERMS);
  logic [15:0] x_reg;
  logic [16:0] term_reg;
  logic [17:0] sum_reg;
  logic [3:0]  cnt;
  logic [16:0] coef;
  logic [32:0] m1;
  logic [33:0] m2;
  logic [16:0] p1;
  logic [16:0] p2;
  logic [16:0] next_term;
  // coef[n] = trunc(2^16 / n); coef[0] is unused by a well-behaved controller
  always_comb begin
    case (cnt)
      4'd1:    coef = 17'h10000;
      4'd2:    coef = 17'h08000;
      4'd3:    coef = 17'h05555;
      4'd4:    coef = 17'h04000;
      4'd5:    coef = 17'h03333;
      4'd6:    coef = 17'h02AAA;
      4'd7:    coef = 17'h02492;
      4'd8:    coef = 17'h02000;
      4'd9:    coef = 17'h01C71;
      4'd10:   coef = 17'h01999;
      4'd11:   coef = 17'h01745;
      4'd12:   coef = 17'h01555;
      4'd13:   coef = 17'h013B1;
      4'd14:   coef = 17'h01249;
      4'd15:   coef = 17'h01111;
      default: coef = 17'h00000;
    endcase
  end
  assign m1 = term_reg * x_reg;
  assign p1 = m1[FRAC +: 17];
  assign m2 = p1 * coef;
  assign p2 = m2[FRAC +: 17];
  assign next_term = selTmp ? p2 : 17'h10000;
  assign done = cnt >= TERMS_C;
  assign result = sum_reg;
  assign term = term_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg <= '0;
      term_reg <= '0;
      sum_reg <= '0;
      cnt <= '0;
    end else if (ldX) begin
      x_reg <= x_in;
      sum_reg <= '0;
      cnt <= '0;
    end else if (ldTmp && !done) begin
      term_reg <= next_term;
      sum_reg <= sum_reg + {1'b0, next_term};
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_exp_taylor_datapath.sv
// tb_exp_taylor_datapath: scoreboard bench; stimulus pushes hand-computed expectations,
// a monitor pops and compares them against a TERMS=4 and a TERMS=8 instance.
module tb_exp_taylor_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x_in = '0;
  logic        ldX = 1'b0;
  logic        ldTmp = 1'b0;
  logic        selTmp = 1'b0;
  logic        done_a, done_b;
  logic [17:0] result_a, result_b;
  logic [16:0] term_a, term_b;
  int total = 0;
  int passed = 0;
  event sample_ev;

  typedef struct {
    string       name;
    logic        b;
    logic [17:0] res;
    logic [17:0] tol;
    logic [16:0] trm;
    logic        chk_trm;
    logic        dn;
    logic [3:0]  cnt;
    logic        chk_cnt;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  exp_taylor_datapath #(.TERMS(4), .FRAC(16)) dut_a (
    .clk(clk), .rst(rst), .x_in(x_in), .ldX(ldX), .ldTmp(ldTmp), .selTmp(selTmp),
    .done(done_a), .result(result_a), .term(term_a)
  );
  exp_taylor_datapath #(.TERMS(8), .FRAC(16)) dut_b (
    .clk(clk), .rst(rst), .x_in(x_in), .ldX(ldX), .ldTmp(ldTmp), .selTmp(selTmp),
    .done(done_b), .result(result_b), .term(term_b)
  );

  task automatic expect_a(input string name, input logic [17:0] res, input logic [16:0] trm,
                          input logic dn, input logic [3:0] cnt);
    exp_t e;
    e.name = name; e.b = 1'b0; e.res = res; e.tol = '0; e.trm = trm; e.chk_trm = 1'b1;
    e.dn = dn; e.cnt = cnt; e.chk_cnt = 1'b1;
    q.push_back(e);
  endtask

  task automatic expect_b(input string name, input logic [17:0] res, input logic [17:0] tol,
                          input logic dn);
    exp_t e;
    e.name = name; e.b = 1'b1; e.res = res; e.tol = tol; e.trm = '0; e.chk_trm = 1'b0;
    e.dn = dn; e.cnt = '0; e.chk_cnt = 1'b0;
    q.push_back(e);
  endtask

  task automatic step(input logic lx, input logic lt, input logic sel, input logic [15:0] xv);
    ldX = lx; ldTmp = lt; selTmp = sel; x_in = xv;
    @(posedge clk);
    #1;
    ldX = 1'b0; ldTmp = 1'b0; selTmp = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [17:0] ar, d;
        logic [16:0] at;
        logic [3:0]  ac;
        logic        ad, ok;
        e = q.pop_front();
        ar = e.b ? result_b : result_a;
        at = e.b ? term_b : term_a;
        ad = e.b ? done_b : done_a;
        ac = e.b ? dut_b.cnt : dut_a.cnt;
        d = (ar >= e.res) ? ar - e.res : e.res - ar;
        ok = (d <= e.tol) && (!e.chk_trm || at == e.trm) && (ad == e.dn) && (!e.chk_cnt || ac == e.cnt);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got result=%h term=%h done=%b cnt=%0d, want result=%h(+-%h) term=%h done=%b cnt=%0d",
                      e.name, ar, at, ad, ac, e.res, e.tol, e.trm, e.dn, e.cnt);
      end
    end
  end

  initial begin : stim
    @(posedge clk); #1;
    expect_a("reset_state", 18'h0, 17'h0, 1'b0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1, 0, 0, 16'h8000); expect_a("x8000_ldx", 18'h0, 17'h0, 0, 0);
    step(0, 1, 0, 16'h0);    expect_a("x8000_t0", 18'h10000, 17'h10000, 0, 1);
    step(0, 1, 1, 16'h0);    expect_a("x8000_t1", 18'h18000, 17'h08000, 0, 2);
    step(0, 1, 1, 16'h0);    expect_a("x8000_t2", 18'h1A000, 17'h02000, 0, 3);
    step(0, 1, 1, 16'h0);    expect_a("x8000_t3", 18'h1A555, 17'h00555, 1, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 16'h0);  expect_a("saturate", 18'h1A555, 17'h00555, 1, 4);
    end
    step(0, 0, 0, 16'h0);    expect_a("idle_hold", 18'h1A555, 17'h00555, 1, 4);
    step(1, 0, 0, 16'h0000); expect_a("x0_ldx", 18'h0, 17'h00555, 0, 0);
    step(0, 1, 0, 16'h0);    expect_a("x0_t0", 18'h10000, 17'h10000, 0, 1);
    step(0, 1, 1, 16'h0);    expect_a("x0_t1", 18'h10000, 17'h0, 0, 2);
    step(0, 1, 1, 16'h0);    expect_a("x0_t2", 18'h10000, 17'h0, 0, 3);
    step(0, 1, 1, 16'h0);    expect_a("x0_t3", 18'h10000, 17'h0, 1, 4);
    step(1, 0, 0, 16'h8000); expect_a("pre_ldx", 18'h0, 17'h0, 0, 0);
    step(0, 1, 0, 16'h0);    expect_a("pre_t0", 18'h10000, 17'h10000, 0, 1);
    step(0, 1, 1, 16'h0);    expect_a("pre_t1", 18'h18000, 17'h08000, 0, 2);
    step(1, 1, 1, 16'h4000); expect_a("ldx_ldtmp", 18'h0, 17'h08000, 0, 0);
    step(0, 1, 0, 16'h0);    expect_a("x4000_t0", 18'h10000, 17'h10000, 0, 1);
    step(0, 1, 1, 16'h0);    expect_a("x4000_t1", 18'h14000, 17'h04000, 0, 2);
    step(0, 1, 1, 16'h0);    expect_a("x4000_t2", 18'h14800, 17'h00800, 0, 3);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    expect_a("async_reset", 18'h0, 17'h0, 0, 0);
    -> sample_ev;
    repeat (2) @(posedge clk);
    #1;
    expect_a("reset_held", 18'h0, 17'h0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 1, 1, 16'h0);    expect_a("post_reset_x0", 18'h0, 17'h0, 0, 1);
    step(1, 0, 0, 16'h4000); expect_a("post_reset_ldx", 18'h0, 17'h0, 0, 0);
    step(0, 1, 0, 16'h0);    expect_a("post_reset_t0", 18'h10000, 17'h10000, 0, 1);
    step(1, 0, 0, 16'hFFFF); expect_b("e_ldx", 18'h0, 18'h0, 0);
    step(0, 1, 0, 16'h0);    expect_b("e_t0", 18'h10000, 18'h0, 0);
    for (int i = 1; i < 7; i++) begin
      step(0, 1, 1, 16'h0);  expect_b("e_mid", 18'h0, 18'h3FFFF, 0);
    end
    step(0, 1, 1, 16'h0);
    expect_b("e_final", 18'h2B7E1, 18'h00010, 1);
    expect_a("e_terms4", 18'h2AAA7, 17'h02AA9, 1, 4);
    step(0, 1, 1, 16'h0);    expect_b("e_saturate", 18'h2B7E1, 18'h00010, 1);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exp_taylor_datapath.md
Name: exp_taylor_datapath

Overview:
- Datapath stage that sits directly downstream of the exponential control unit.
- Consumes its ldX, ldTmp and selTmp strobes; returns done to it.
- Computes e^x by truncated Taylor series: term_n = term_(n-1) * x * (1/n), sum = sum of term_0..term_(TERMS-1).
- Operands are unsigned fixed point. x is Q0.16, term is Q1.16, sum is Q2.16.

Parameters:
- TERMS, 8, number of series terms accumulated before done; legal range 1..15.
- FRAC, 16, fractional bits of x/term/sum; fixed at 16 (coefficient ROM is built for it).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- x_in  input  16  operand x, Q0.16, sampled on ldX.
- ldX  input  1  load x; clear counter and sum.
- ldTmp  input  1  compute next term, load term register, accumulate into sum, increment counter.
- selTmp  input  1  term-source select: 0 = constant 1.0 (0x10000), 1 = recursive product.
- done  output  1  high while cnt >= TERMS.
- result  output  18  e^x approximation, Q2.16 (sum register).
- term  output  17  current term register, Q1.16, for debug/visibility.

Behaviour:
- Registers: x_reg[15:0], term_reg[16:0], sum_reg[17:0], cnt[3:0]. All cleared to 0 asynchronously while rst=0.
- Reset values: done=0 (unless TERMS=0, which is illegal), result=0, term=0.
- Coefficient ROM coef[cnt] = trunc(2^16/cnt), Q1.16:
  - coef[0]=0, [1]=0x10000, [2]=0x8000, [3]=0x5555, [4]=0x4000, [5]=0x3333, [6]=0x2AAA, [7]=0x2492,
  - [8]=0x2000, [9]=0x1C71, [10]=0x1999, [11]=0x1745, [12]=0x1555, [13]=0x13B1, [14]=0x1249, [15]=0x1111.
- Next-term datapath (combinational, single cycle):
  - p1 = (term_reg * x_reg) >> 16, truncated to 17 bits.
  - p2 = (p1 * coef[cnt]) >> 16, truncated to 17 bits.
  - next_term = selTmp ? p2 : 17'h10000.
- ldX, priority over ldTmp. On the clock edge: x_reg <= x_in, cnt <= 0, sum_reg <= 0; term_reg holds. A simultaneous ldTmp is ignored.
- ldTmp with ldX=0 and done=0. On the clock edge: term_reg <= next_term, sum_reg <= sum_reg + next_term (18-bit, no overflow for x < 1), cnt <= cnt + 1.
- ldTmp while done=1: ignored; all registers hold. The counter never wraps.
- selTmp=1 with cnt=0 gives coef 0, so next_term = 0. This is legal, but the controller must issue selTmp=0 for the first term.
- Latency and outputs:
  - Each ldTmp updates result and term one cycle later.
  - done is combinational from cnt (cnt >= TERMS), so it asserts in the cycle after the TERMS-th accumulating ldTmp.
  - done stays high until ldX or reset.
- Neither strobe asserted: all registers hold.
- Reset mid-series: immediate clear of all registers; done drops. A new series requires ldX.
- selTmp is don't-care when ldTmp=0.

Test Plan:
- Reset: rst=0 for 2 cycles mid-series (cnt=3) -> result=0, term=0, cnt=0, done=0 immediately (asynchronous), before the next clock edge.
- TERMS=4, x_in=0x8000, sequence:
  - ldX, then ldTmp with selTmp=0, then 3x ldTmp with selTmp=1.
  - term sequence: 0x10000, 0x8000, 0x2000, 0x0555.
  - result: 0x1A555; done=1 one cycle after the 4th ldTmp.
- TERMS=4, x_in=0x0000, same sequence -> terms 0x10000, 0, 0, 0; result=0x10000; done=1.
- Saturation of count: TERMS=4, after done, issue 3 more ldTmp -> result, term and cnt unchanged; done stays 1.
- ldX and ldTmp in the same cycle with cnt=2, sum nonzero, x_in=0x4000 -> x_reg=0x4000, cnt=0, sum=0, term unchanged; ldTmp has no effect.
- TERMS=8, x_in=0xFFFF (≈1.0):
  - Standard sequence gives result within 0x0010 of 0x2B7E1 (e ≈ 2.71828), accounting for truncation.
  - done asserts after exactly 8 ldTmp.
